// File: rtl/rr_packet_grant_stage.sv
// rr_packet_grant_stage: takes the arbiter's one-hot grant and loads the
// winning requester's beat into a single registered output slot. Multi-beat
// packets are kept together by locking onto the owner until its last beat.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | between packets; a grant on a loading cycle starts a new packet
// LOCKED | mid-packet; only the owner's beats are taken, grant is ignored
module rr_packet_grant_stage #(
  parameter int request_lines = 4,
  parameter int data_width    = 32,
  localparam int SRC_W        = $clog2(request_lines)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [request_lines-1:0]            req,
  input  logic [request_lines*data_width-1:0] req_data,
  input  logic [request_lines-1:0]            req_last,
  input  logic [request_lines-1:0]            grant,
  output logic [request_lines-1:0]            req_ack,
  output logic                                out_valid,
  output logic [data_width-1:0]               out_data,
  output logic                                out_last,
  output logic [SRC_W-1:0]                    out_src,
  input  logic                                out_ready,
  output logic                                grant_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [request_lines-1:0] ONE = {{(request_lines-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        owner_q, owner_d;
  logic                    out_valid_q, out_valid_d;
  logic [data_width-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    grant_err_q, grant_err_d;

  logic                    can_load;
  logic                    load;
  logic [SRC_W-1:0]        ld_idx;
  logic [SRC_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic                    gnt_multi;

  // Lowest set bit of grant, plus a check for more than one bit set.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = request_lines - 1; i >= 0; i--) begin
      if (grant[i]) begin
        gnt_idx = SRC_W'(i);
        gnt_any = 1'b1;
      end
    end
    gnt_multi = (grant & (grant - ONE)) != '0;
  end

  // Next-state, load decision and slot update; grant only counts on a loading cycle in IDLE.
  always_comb begin
    can_load    = !out_valid_q || out_ready;
    load        = 1'b0;
    ld_idx      = owner_q;
    state_d     = state_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    grant_err_d = grant_err_q;

    case (state_q)
      IDLE: begin
        if (can_load && gnt_multi) grant_err_d = 1'b1;
        // A grant without a matching request would violate the ack contract, so it is not taken.
        if (can_load && gnt_any && req[gnt_idx]) begin
          load   = 1'b1;
          ld_idx = gnt_idx;
        end
      end
      LOCKED: begin
        if (can_load && req[owner_q]) begin
          load   = 1'b1;
          ld_idx = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(ld_idx)*data_width +: data_width];
      out_last_d  = req_last[ld_idx];
      out_src_d   = ld_idx;
      owner_d     = ld_idx;
      state_d     = req_last[ld_idx] ? IDLE : LOCKED;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    req_ack = load ? (ONE << ld_idx) : '0;
  end

  // State and output slot registers; reset drops any lock and empties the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_rr_packet_grant_stage.sv
// Directed bench for rr_packet_grant_stage: one table row per clock cycle,
// plus a hand-written asynchronous reset sequence mid-packet.
module tb_rr_packet_grant_stage;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    grant;
  logic [N-1:0]    req_ack;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            grant_err;

  int checks = 0;
  int errors = 0;

  rr_packet_grant_stage #(.request_lines(N), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .req_ack(req_ack), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .out_ready(out_ready), .grant_err(grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [N-1:0]  last;
    logic [31:0]   dat;
    logic          rdy;
    logic [N-1:0]  ack;
    logic          v;
    logic [31:0]   d;
    logic          l;
    logic [1:0]    s;
    logic          err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic [N-1:0] rq, logic [N-1:0] gn, logic [N-1:0] ls,
                              logic [31:0] dt, logic rd, logic [N-1:0] ak, logic vv,
                              logic [31:0] dd, logic ll, logic [1:0] ss, logic ee);
    vec_t t;
    t.req = rq; t.grant = gn; t.last = ls; t.dat = dt; t.rdy = rd;
    t.ack = ak; t.v = vv; t.d = dd; t.l = ll; t.s = ss; t.err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane i carries the requester index in the top byte so the source is visible in out_data.
  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] gn, input logic [N-1:0] ls,
                       input logic [31:0] dt, input logic rd);
    req = rq; grant = gn; req_last = ls; out_ready = rd;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {8'(i), dt[23:0]};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           req      grant    last     dat      rdy   ack      v     d             l     s     err
    // single-beat packet from requester 2
    vecs[0]  = mk(4'b0100, 4'b0100, 4'b0100, 32'hA5, 1'b1, 4'b0100, 1'b1, 32'h020000A5, 1'b1, 2'd2, 1'b0);
    // 3-beat packet from requester 1; grant moves to 3 mid-packet
    vecs[1]  = mk(4'b1010, 4'b0010, 4'b0000, 32'h11, 1'b1, 4'b0010, 1'b1, 32'h01000011, 1'b0, 2'd1, 1'b0);
    vecs[2]  = mk(4'b1010, 4'b1000, 4'b0000, 32'h12, 1'b1, 4'b0010, 1'b1, 32'h01000012, 1'b0, 2'd1, 1'b0);
    vecs[3]  = mk(4'b1010, 4'b1000, 4'b0010, 32'h13, 1'b1, 4'b0010, 1'b1, 32'h01000013, 1'b1, 2'd1, 1'b0);
    vecs[4]  = mk(4'b1000, 4'b1000, 4'b1000, 32'h14, 1'b1, 4'b1000, 1'b1, 32'h03000014, 1'b1, 2'd3, 1'b0);
    // back-pressure for 4 cycles; a multi-bit grant here must not flag
    vecs[5]  = mk(4'b0001, 4'b0001, 4'b0000, 32'h20, 1'b0, 4'b0000, 1'b1, 32'h03000014, 1'b1, 2'd3, 1'b0);
    vecs[6]  = mk(4'b0011, 4'b0010, 4'b0000, 32'h21, 1'b0, 4'b0000, 1'b1, 32'h03000014, 1'b1, 2'd3, 1'b0);
    vecs[7]  = mk(4'b0111, 4'b0110, 4'b0000, 32'h22, 1'b0, 4'b0000, 1'b1, 32'h03000014, 1'b1, 2'd3, 1'b0);
    vecs[8]  = mk(4'b0001, 4'b0001, 4'b0000, 32'h23, 1'b0, 4'b0000, 1'b1, 32'h03000014, 1'b1, 2'd3, 1'b0);
    // drain and load in the same cycle; requester 0 starts a packet
    vecs[9]  = mk(4'b0001, 4'b0001, 4'b0000, 32'h24, 1'b1, 4'b0001, 1'b1, 32'h00000024, 1'b0, 2'd0, 1'b0);
    // owner stalls for 2 cycles while requester 3 is granted
    vecs[10] = mk(4'b1000, 4'b1000, 4'b1000, 32'h25, 1'b1, 4'b0000, 1'b0, 32'h00000024, 1'b0, 2'd0, 1'b0);
    vecs[11] = mk(4'b1000, 4'b1000, 4'b1000, 32'h25, 1'b1, 4'b0000, 1'b0, 32'h00000024, 1'b0, 2'd0, 1'b0);
    vecs[12] = mk(4'b1001, 4'b1000, 4'b0001, 32'h26, 1'b1, 4'b0001, 1'b1, 32'h00000026, 1'b1, 2'd0, 1'b0);
    // non-one-hot grant on a loading cycle, then sticky flag
    vecs[13] = mk(4'b0110, 4'b0110, 4'b0110, 32'h30, 1'b1, 4'b0010, 1'b1, 32'h01000030, 1'b1, 2'd1, 1'b1);
    vecs[14] = mk(4'b0000, 4'b0000, 4'b0000, 32'h31, 1'b1, 4'b0000, 1'b0, 32'h01000030, 1'b1, 2'd1, 1'b1);

    rst = 1'b0;
    drive('0, '0, '0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_err",   32'(grant_err), 32'd0);
    chk("rst_ack",   32'(req_ack),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drive(vecs[k].req, vecs[k].grant, vecs[k].last, vecs[k].dat, vecs[k].rdy);
      #1;
      chk($sformatf("v%0d_ack", k), 32'(req_ack), 32'(vecs[k].ack));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].v));
      chk($sformatf("v%0d_data", k),  out_data,       vecs[k].d);
      chk($sformatf("v%0d_last", k),  32'(out_last),  32'(vecs[k].l));
      chk($sformatf("v%0d_src", k),   32'(out_src),   32'(vecs[k].s));
      chk($sformatf("v%0d_err", k),   32'(grant_err), 32'(vecs[k].err));
    end

    // Start a packet from requester 2 and leave it mid-flight with the slot full.
    @(negedge clk);
    drive(4'b0100, 4'b0100, 4'b0000, 32'h40, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_src",   32'(out_src),   32'd2);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000, 32'h41, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data",  out_data,       32'd0);
    chk("async_rst_err",   32'(grant_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // If the lock to requester 2 survived, this grant to 3 would be ignored.
    @(negedge clk);
    drive(4'b1001, 4'b1000, 4'b1000, 32'h50, 1'b1);
    #1;
    chk("post_rst_ack", 32'(req_ack), 32'b1000);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  out_data,       32'h03000050);
    chk("post_rst_src",   32'(out_src),   32'd3);
    chk("post_rst_last",  32'(out_last),  32'd1);

    // Idle next cycle with nothing requested: slot drains.
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000, 32'h51, 1'b1);
    #1;
    chk("idle_ack", 32'(req_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packet_grant_stage.md
# rr_packet_grant_stage

Downstream consumer of the round-robin mask arbiter's one-hot `grant`. It muxes the winning requester's payload into a single registered output slot with valid/ready flow control, and returns per-requester accept pulses. It locks onto the granted requester for the length of a multi-beat packet, ignoring `grant` until that packet's last beat is taken. The arbiter therefore decides only packet starts. This stage enforces packet atomicity and output back-pressure.

## Interface
Parameters:
- `request_lines`, default 4: number of requesters; must be ≥2 and match the arbiter.
- `data_width`, default 32: payload bits per beat.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, request_lines: per-requester beat-valid; the same vector drives the arbiter's `req`.
- `req_data`, input, request_lines*data_width: requester i's payload in bits `[i*data_width +: data_width]`.
- `req_last`, input, request_lines: requester i's current beat ends its packet.
- `grant`, input, request_lines: one-hot grant from the arbiter, combinational in the same cycle.
- `req_ack`, output, request_lines: combinational; requester i's beat is consumed this cycle.
- `out_valid`, output, 1: output slot holds a beat.
- `out_data`, output, data_width: registered payload.
- `out_last`, output, 1: registered last flag.
- `out_src`, output, $clog2(request_lines): index of the requester that sourced the beat.
- `out_ready`, input, 1: downstream accepts the beat when `out_valid && out_ready`.
- `grant_err`, output, 1: sticky flag; `grant` was seen non-one-hot while sampled.

## Operation
- `can_load = !out_valid || out_ready`.
- Internal state:
  - FSM with states IDLE and LOCKED.
  - `owner` register, $clog2(request_lines) bits.
- IDLE:
  - If `can_load` and `grant != 0`: the selected index is the lowest set bit of `grant`.
    - Load `req_data`/`req_last` of that index into the output slot.
    - Set `out_src` to the index.
    - Pulse `req_ack[index]`.
    - Write `owner` with the index.
  - If the loaded beat has `req_last=0`, go to LOCKED; otherwise stay in IDLE.
  - If `grant` has more than one bit set when sampled under `can_load`, set `grant_err`. It stays set until reset.
  - `grant` is ignored when `can_load=0`. The arbiter may rotate meanwhile; only the grant on the loading cycle matters.
- LOCKED:
  - `grant` is ignored entirely.
  - If `can_load` and `req[owner]`: load the owner's beat, pulse `req_ack[owner]`.
  - If that beat has `req_last=1`, go to IDLE.
  - If `req[owner]=0`, hold state; no ack and no load.
- `req_ack` has at most one bit set. It is never asserted for a requester whose `req` is low.
- When no load occurs and `out_ready` is high, `out_valid` clears next cycle.
- Output slot contents are unchanged while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous assert):
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - `grant_err=0`, state=IDLE, `owner=0`.
  - `req_ack=0`, since it is combinational from the cleared state.
- Reset mid-packet discards the lock and the slot contents. The first post-reset beat is arbitrated afresh.
- Latency: the beat acked in cycle N appears on `out_*` with `out_valid=1` in cycle N+1.
- Throughput: one beat per cycle when `out_ready` is held high.
  - A drain and a load in the same cycle is legal and gives back-to-back beats.
- Single-beat packet (`req_last=1` on its first beat): no LOCKED cycle. The next packet start may be taken the following cycle.
- Simultaneous events:
  - Load with `out_ready=1` replaces the slot; no bubble.
  - Last beat of a packet in LOCKED returns to IDLE. The next grant is honoured in the next cycle, not the same cycle.
- `out_src` width is `$clog2(request_lines)`. Index arithmetic is unsigned with no wrap.

## Test plan
- Reset, then requester 2 drives a 1-beat packet (`req=4'b0100`, `grant=4'b0100`, `req_last=1`, data `0xA5`) with `out_ready=1` → `req_ack=4'b0100` in cycle 0. In cycle 1: `out_valid=1`, `out_data=0xA5`, `out_src=2`, `out_last=1`. State stays IDLE.
- Requester 1 sends a 3-beat packet while requester 3 also requests and the grant toggles to 3 mid-packet → all three acks go to requester 1 and `out_src=1` for all three beats. Requester 3 is acked only after requester 1's last beat.
- Back-pressure: `out_ready=0` for 4 cycles with the slot full → `req_ack=0` and `out_*` stable for those cycles. On `out_ready=1`, the slot drains and the next beat loads in the same cycle.
- LOCKED with `req[owner]=0` for 2 cycles → no ack, `out_valid` drops after draining, and the lock is held. On resume, beats continue from the same owner.
- `grant=4'b0110` with `can_load=1` → `req_ack=4'b0010`, `grant_err=1`, and it remains 1 until `rst` is low.
- Assert `rst` low mid-packet with `out_valid=1` → `out_valid=0` immediately (asynchronously), state returns to IDLE, and after release the next grant is honoured.
